// File: rtl/controle_pkg.sv
// Shared types and constants for the lighting controller.
package controle_pkg;

  typedef enum logic [1:0] {
    AUTO_OFF   = 2'd0,
    AUTO_ON    = 2'd1,
    MANUAL_OFF = 2'd2,
    MANUAL_ON  = 2'd3
  } estado_t;

  // Default lamp hold time in auto mode, counted in tick_1ms periods (30 s).
  localparam int AUTO_SHUTDOWN_T_DEFAULT = 30000;

  // Lamp is driven in both "on" states regardless of mode.
  function automatic logic lampOn(input estado_t s);
    return (s == AUTO_ON) || (s == MANUAL_ON);
  endfunction

  // Mode indicator is lit in both manual states.
  function automatic logic manualMode(input estado_t s);
    return (s == MANUAL_OFF) || (s == MANUAL_ON);
  endfunction

endpackage

// File: rtl/sincronizador.sv
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
module sincronizador (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // First flop may go metastable; the second gives it a full cycle to resolve.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/controle_iluminacao.sv
// Room lighting controller: IR-triggered auto mode with a retriggerable
// hold timer, plus a manual mode toggled by a short-press button.
module controle_iluminacao
  import controle_pkg::*;
#(
  parameter int AUTO_SHUTDOWN_T = AUTO_SHUTDOWN_T_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_1ms,
  input  logic infravermelho,
  input  logic a,
  input  logic b,
  output logic saida,
  output logic led
);

  localparam int CntW = $clog2(AUTO_SHUTDOWN_T + 1);
  localparam logic [CntW-1:0] CntLoad = CntW'(AUTO_SHUTDOWN_T);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  logic            ir_s;
  estado_t         state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            saida_q, led_q;

  sincronizador u_sinc_ir (
    .clk (clk),
    .rst (rst),
    .d_i (infravermelho),
    .q_o (ir_s)
  );

  // Next state and counter; b outranks a, a outranks IR, IR outranks timeout.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      AUTO_OFF: begin
        if (b) begin
          state_d = MANUAL_OFF;
          cnt_d   = '0;
        end else if (ir_s) begin
          state_d = AUTO_ON;
          cnt_d   = CntLoad;
        end
      end
      AUTO_ON: begin
        if (b) begin
          state_d = MANUAL_ON;
          cnt_d   = '0;
        end else if (ir_s) begin
          cnt_d = CntLoad;
        end else if (tick_1ms) begin
          // Treating 0 like 1 keeps the counter from ever wrapping.
          if (cnt_q <= CntOne) begin
            state_d = AUTO_OFF;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CntOne;
          end
        end
      end
      MANUAL_OFF: begin
        cnt_d = '0;
        if (b) begin
          state_d = AUTO_OFF;
        end else if (a) begin
          state_d = MANUAL_ON;
        end
      end
      MANUAL_ON: begin
        cnt_d = '0;
        if (b) begin
          state_d = AUTO_OFF;
        end else if (a) begin
          state_d = MANUAL_OFF;
        end
      end
      default: begin
        state_d = AUTO_OFF;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and decoded outputs all update on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= AUTO_OFF;
      cnt_q   <= '0;
      saida_q <= 1'b0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      saida_q <= lampOn(state_d);
      led_q   <= manualMode(state_d);
    end
  end

  assign saida = saida_q;
  assign led   = led_q;

endmodule

// File: tb/tb_controle_iluminacao.sv
// Directed bench for controle_iluminacao with a 5-tick hold time and
// tick_1ms asserted on every 4th clk edge.
module tb_controle_iluminacao;
  import controle_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick_1ms = 1'b0;
  logic infravermelho = 1'b0;
  logic a = 1'b0;
  logic b = 1'b0;
  logic saida;
  logic led;

  int checks = 0;
  int failures = 0;
  int edgeCnt = 0;

  controle_iluminacao #(.AUTO_SHUTDOWN_T(5)) dut (
    .clk           (clk),
    .rst           (rst),
    .tick_1ms      (tick_1ms),
    .infravermelho (infravermelho),
    .a             (a),
    .b             (b),
    .saida         (saida),
    .led           (led)
  );

  // 10 ns clock
  initial forever #5 clk = ~clk;

  // Advance one edge and land 1 ns after it; tick fires on edges that are multiples of 4.
  task automatic clockStep();
    @(posedge clk);
    #1;
    edgeCnt++;
    tick_1ms = ((edgeCnt + 1) % 4 == 0);
  endtask

  // Stop just after an edge numbered as a multiple of 4 so tick timing is known.
  task automatic alignPhase();
    clockStep();
    while (edgeCnt % 4 != 0) clockStep();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    checks++;
    if (saida !== 1'b0 || led !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_async saida=%b led=%b expected 0 0", saida, led);
    end
    clockStep();
    clockStep();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      clockStep();
      checks++;
      if (saida !== 1'b0 || led !== 1'b0 || dut.state_q !== AUTO_OFF) begin
        failures++;
        $display("[TB] FAIL reset_idle cyc=%0d saida=%b led=%b state=%0d expected 0 0 AUTO_OFF",
                 i, saida, led, dut.state_q);
      end
    end
  endtask

  task automatic test_auto_timeout();
    logic expS;
    alignPhase();
    infravermelho = 1'b1;
    for (int r = 1; r <= 34; r++) begin
      clockStep();
      if (r == 10) infravermelho = 1'b0;
      expS = (r >= 3 && r <= 31);
      checks++;
      if (saida !== expS || led !== 1'b0) begin
        failures++;
        $display("[TB] FAIL auto_timeout r=%0d saida=%b led=%b expected %b 0", r, saida, led, expS);
      end
    end
  endtask

  task automatic test_retrigger();
    alignPhase();
    infravermelho = 1'b1;
    for (int r = 1; r <= 46; r++) begin
      clockStep();
      if (r == 10) infravermelho = 1'b0;
      if (r == 24) begin
        checks++;
        if (dut.cnt_q !== 3'd2) begin
          failures++;
          $display("[TB] FAIL retrig_cnt_before got=%0d expected 2", dut.cnt_q);
        end
        infravermelho = 1'b1;
      end
      if (r == 25) infravermelho = 1'b0;
      if (r == 27) begin
        checks++;
        if (dut.cnt_q !== 3'd5) begin
          failures++;
          $display("[TB] FAIL retrig_reload got=%0d expected 5", dut.cnt_q);
        end
      end
      if (r == 32 || r == 43) begin
        checks++;
        if (saida !== 1'b1) begin
          failures++;
          $display("[TB] FAIL retrig_still_on r=%0d saida=%b expected 1", r, saida);
        end
      end
      if (r == 44 || r == 46) begin
        checks++;
        if (saida !== 1'b0) begin
          failures++;
          $display("[TB] FAIL retrig_off r=%0d saida=%b expected 0", r, saida);
        end
      end
    end
  endtask

  task automatic test_mode_switch();
    alignPhase();
    infravermelho = 1'b1;
    for (int r = 1; r <= 5; r++) begin
      clockStep();
      if (r == 2) infravermelho = 1'b0;
    end
    checks++;
    if (saida !== 1'b1 || led !== 1'b0) begin
      failures++;
      $display("[TB] FAIL mode_auto_on saida=%b led=%b expected 1 0", saida, led);
    end
    b = 1'b1;
    clockStep();
    b = 1'b0;
    checks++;
    if (saida !== 1'b1 || led !== 1'b1 || dut.state_q !== MANUAL_ON || dut.cnt_q !== 3'd0) begin
      failures++;
      $display("[TB] FAIL mode_to_manual_on saida=%b led=%b state=%0d cnt=%0d expected 1 1 3 0",
               saida, led, dut.state_q, dut.cnt_q);
    end
    for (int i = 0; i < 40; i++) begin
      infravermelho = ~infravermelho;
      clockStep();
      checks++;
      if (saida !== 1'b1 || led !== 1'b1 || dut.cnt_q !== 3'd0) begin
        failures++;
        $display("[TB] FAIL mode_ir_ignored cyc=%0d saida=%b led=%b cnt=%0d expected 1 1 0",
                 i, saida, led, dut.cnt_q);
      end
    end
    infravermelho = 1'b0;
    repeat (4) clockStep();
    b = 1'b1;
    clockStep();
    b = 1'b0;
    checks++;
    if (saida !== 1'b0 || led !== 1'b0 || dut.state_q !== AUTO_OFF) begin
      failures++;
      $display("[TB] FAIL mode_exit saida=%b led=%b state=%0d expected 0 0 AUTO_OFF",
               saida, led, dut.state_q);
    end
    repeat (4) clockStep();
    checks++;
    if (saida !== 1'b0 || led !== 1'b0) begin
      failures++;
      $display("[TB] FAIL mode_exit_hold saida=%b led=%b expected 0 0", saida, led);
    end
  endtask

  task automatic test_manual_toggle();
    b = 1'b1;
    clockStep();
    b = 1'b0;
    checks++;
    if (saida !== 1'b0 || led !== 1'b1) begin
      failures++;
      $display("[TB] FAIL manual_enter_off saida=%b led=%b expected 0 1", saida, led);
    end
    a = 1'b1;
    clockStep();
    a = 1'b0;
    checks++;
    if (saida !== 1'b1 || led !== 1'b1) begin
      failures++;
      $display("[TB] FAIL manual_a_on saida=%b led=%b expected 1 1", saida, led);
    end
    a = 1'b1;
    clockStep();
    a = 1'b0;
    checks++;
    if (saida !== 1'b0 || led !== 1'b1) begin
      failures++;
      $display("[TB] FAIL manual_a_off saida=%b led=%b expected 0 1", saida, led);
    end
    a = 1'b1;
    b = 1'b1;
    clockStep();
    a = 1'b0;
    b = 1'b0;
    checks++;
    if (saida !== 1'b0 || led !== 1'b0 || dut.state_q !== AUTO_OFF) begin
      failures++;
      $display("[TB] FAIL manual_ab_priority saida=%b led=%b state=%0d expected 0 0 AUTO_OFF",
               saida, led, dut.state_q);
    end
    a = 1'b1;
    clockStep();
    a = 1'b0;
    checks++;
    if (saida !== 1'b0 || led !== 1'b0 || dut.state_q !== AUTO_OFF) begin
      failures++;
      $display("[TB] FAIL auto_a_ignored saida=%b led=%b state=%0d expected 0 0 AUTO_OFF",
               saida, led, dut.state_q);
    end
  endtask

  task automatic test_async_reset();
    alignPhase();
    infravermelho = 1'b1;
    for (int r = 1; r <= 20; r++) begin
      clockStep();
      if (r == 10) infravermelho = 1'b0;
    end
    checks++;
    if (dut.cnt_q !== 3'd3 || saida !== 1'b1) begin
      failures++;
      $display("[TB] FAIL areset_pre cnt=%0d saida=%b expected 3 1", dut.cnt_q, saida);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (saida !== 1'b0 || led !== 1'b0 || dut.cnt_q !== 3'd0 || dut.state_q !== AUTO_OFF) begin
      failures++;
      $display("[TB] FAIL areset_immediate saida=%b led=%b cnt=%0d state=%0d expected 0 0 0 AUTO_OFF",
               saida, led, dut.cnt_q, dut.state_q);
    end
    #2;
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      clockStep();
      checks++;
      if (saida !== 1'b0 || dut.state_q !== AUTO_OFF) begin
        failures++;
        $display("[TB] FAIL areset_after cyc=%0d saida=%b state=%0d expected 0 AUTO_OFF",
                 i, saida, dut.state_q);
      end
    end
  endtask

  // Runs every scenario in order, then reports.
  initial begin
    test_reset();
    test_auto_timeout();
    test_retrigger();
    test_mode_switch();
    test_manual_toggle();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
